// File: rtl/rms_sumsq_to_bf16.sv
// rms_sumsq_to_bf16
//   Accumulates the squares of a stream of signed fixed-point activations.
//   At end of vector the sum is scaled by a supplied 1/N, epsilon is added,
//   and the resulting mean-square is converted to bfloat16 (RNE) and emitted
//   as a one-cycle x/x_vld pulse for the downstream inverse-sqrt pipe.
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   in_data    signed element, FRAC_W fractional bits
//   in_vld     element valid
//   in_last    final element of the vector (qualified by in_vld)
//   in_rdy     element can be accepted this cycle (ACC state only)
//   recip_len  unsigned Q0.16 reciprocal of vector length, sampled with in_last
//   x          bfloat16 mean-square + eps, held until the next conversion
//   x_vld      one-cycle pulse, x valid
module rms_sumsq_to_bf16 #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int LEN_W  = 10,
  parameter int EPS    = 1,
  parameter int ACC_W  = 2*DATA_W + LEN_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_vld,
  input  logic                     in_last,
  output logic                     in_rdy,
  input  logic [15:0]              recip_len,
  output logic [15:0]              x,
  output logic                     x_vld
);

  localparam int MS_W   = ACC_W + 1;
  localparam int PROD_W = ACC_W + 16;
  localparam int P_W    = $clog2(MS_W);

  typedef enum logic [1:0] {
    S_ACC   = 2'd0,
    S_SCALE = 2'd1,
    S_NORM  = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ACC_W-1:0]  r_acc;
  logic [15:0]       r_recip;
  logic [MS_W-1:0]   r_ms;
  logic [15:0]       r_x;

  logic                     w_xfer;
  logic signed [2*DATA_W-1:0] w_sq;
  logic [ACC_W-1:0]         w_sq_ext;
  logic [PROD_W-1:0]        w_prod;
  logic [MS_W-1:0]          w_ms_nxt;

  logic [P_W-1:0]    w_p;
  logic              w_nz;
  logic [MS_W-1:0]   w_norm;
  logic [6:0]        w_mant;
  logic              w_guard;
  logic              w_sticky;
  logic              w_round;
  logic [7:0]        w_mant_r;
  logic [15:0]       w_exp_base;
  logic [7:0]        w_exp;
  logic [15:0]       w_bf;

  assign in_rdy = (r_state == S_ACC);
  assign x_vld  = (r_state == S_EMIT);
  assign x      = r_x;
  assign w_xfer = in_vld & in_rdy;

  // Signed square is never negative, so zero extension into the accumulator is exact.
  assign w_sq     = in_data * in_data;
  assign w_sq_ext = {{(ACC_W-2*DATA_W){1'b0}}, w_sq};

  assign w_prod   = r_acc * r_recip;
  assign w_ms_nxt = MS_W'(w_prod >> 16) + MS_W'(EPS);

  // Leading-one search; the highest set bit wins because later iterations overwrite.
  always_comb begin
    w_p  = '0;
    w_nz = 1'b0;
    for (int unsigned i = 0; i < MS_W; i++) begin
      if (r_ms[i]) begin
        w_p  = P_W'(i);
        w_nz = 1'b1;
      end
    end
  end

  // Left-justify so the leading one sits at the MSB; mantissa, guard and sticky
  // then come from fixed positions and small values are zero-filled naturally.
  always_comb begin
    w_norm     = r_ms << (P_W'(MS_W-1) - w_p);
    w_mant     = w_norm[MS_W-2 -: 7];
    w_guard    = w_norm[MS_W-9];
    w_sticky   = |w_norm[MS_W-10:0];
    w_round    = w_guard & (w_sticky | w_mant[0]);
    w_mant_r   = {1'b0, w_mant} + {7'd0, w_round};
    w_exp_base = 16'(w_p) - 16'(2*FRAC_W) + 16'd127;
    // A rounding carry-out leaves w_mant_r[6:0] at zero and bumps the exponent.
    w_exp      = w_exp_base[7:0] + {7'd0, w_mant_r[7]};
    w_bf       = w_nz ? {1'b0, w_exp, w_mant_r[6:0]} : 16'h0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_ACC;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ACC:   if (w_xfer && in_last) w_state_nxt = S_SCALE;
      S_SCALE: w_state_nxt = S_NORM;
      S_NORM:  w_state_nxt = S_EMIT;
      S_EMIT:  w_state_nxt = S_ACC;
      default: w_state_nxt = S_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_recip <= '0;
      r_ms    <= '0;
      r_x     <= '0;
    end else begin
      if (r_state == S_EMIT) begin
        r_acc <= '0;
      end else if (w_xfer) begin
        r_acc <= r_acc + w_sq_ext;
      end
      if (w_xfer && in_last) begin
        r_recip <= recip_len;
      end
      if (r_state == S_SCALE) begin
        r_ms <= w_ms_nxt;
      end
      if (r_state == S_NORM) begin
        r_x <= w_bf;
      end
    end
  end

endmodule

// File: tb/tb_rms_sumsq_to_bf16.sv
module tb_rms_sumsq_to_bf16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] in_data   = '0;
  logic        in_vld    = 1'b0;
  logic        in_last   = 1'b0;
  logic [15:0] recip_len = '0;

  logic        rdy0, rdy1, rdy2;
  logic [15:0] x0, x1, x2;
  logic        v0, v1, v2;

  rms_sumsq_to_bf16 #(.EPS(1)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .in_last(in_last),
    .in_rdy(rdy0), .recip_len(recip_len), .x(x0), .x_vld(v0));

  rms_sumsq_to_bf16 #(.EPS(256)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .in_last(in_last),
    .in_rdy(rdy1), .recip_len(recip_len), .x(x1), .x_vld(v1));

  rms_sumsq_to_bf16 #(.EPS(768)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .in_last(in_last),
    .in_rdy(rdy2), .recip_len(recip_len), .x(x2), .x_vld(v2));

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  longint      m_acc = 0;
  int          m_gap = 0;

  function automatic longint model_ms(longint acc, longint recip, longint eps);
    return ((acc * recip) >>> 16) + eps;
  endfunction

  function automatic logic [15:0] to_bf16(longint ms);
    int     p;
    longint mant8, rem, half;
    logic [7:0] e;
    if (ms == 0) return 16'h0000;
    p = 0;
    while ((ms >>> (p + 1)) != 0) p++;
    if (p > 7) begin
      mant8 = ms >>> (p - 7);
      rem   = ms & ((64'sd1 <<< (p - 7)) - 1);
      half  = 64'sd1 <<< (p - 8);
      if (rem > half || (rem == half && (mant8 & 1) == 1)) mant8++;
      if (mant8 == 256) begin
        mant8 = 128;
        p++;
      end
    end else begin
      mant8 = ms <<< (7 - p);
    end
    e = 8'(p - 16 + 127);
    return {1'b0, e, 7'(mant8)};
  endfunction

  // Reference model: tracks accepted elements and the 3-cycle gap after in_last.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc <= 0;
      m_gap <= 0;
      q0.delete();
      q1.delete();
      q2.delete();
    end else if (m_gap != 0) begin
      m_gap <= m_gap - 1;
    end else if (in_vld) begin
      if (in_last) begin
        q0.push_back(to_bf16(model_ms(m_acc + longint'($signed(in_data)) * longint'($signed(in_data)), longint'(recip_len), 1)));
        q1.push_back(to_bf16(model_ms(m_acc + longint'($signed(in_data)) * longint'($signed(in_data)), longint'(recip_len), 256)));
        q2.push_back(to_bf16(model_ms(m_acc + longint'($signed(in_data)) * longint'($signed(in_data)), longint'(recip_len), 768)));
        m_acc <= 0;
        m_gap <= 3;
      end else begin
        m_acc <= m_acc + longint'($signed(in_data)) * longint'($signed(in_data));
      end
    end
  end

  // Per-cycle handshake/pulse check and scoreboard pop.
  always @(negedge clk) begin
    checks++;
    if ({rdy0, rdy1, rdy2} !== {3{m_gap == 0}}) begin
      errors++;
      $display("FAIL in_rdy t=%0t got=%b%b%b expected=%b", $time, rdy0, rdy1, rdy2, m_gap == 0);
    end
    checks++;
    if ({v0, v1, v2} !== {3{m_gap == 1}}) begin
      errors++;
      $display("FAIL x_vld t=%0t got=%b%b%b expected=%b", $time, v0, v1, v2, m_gap == 1);
    end
    if (v0) begin
      pulses++;
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL sb0_extra t=%0t x=%h", $time, x0);
      end else if (x0 !== q0[0]) begin
        errors++;
        $display("FAIL sb0_x t=%0t got=%h expected=%h", $time, x0, q0[0]);
      end
      if (q0.size() != 0) void'(q0.pop_front());
    end
    if (v1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL sb1_extra t=%0t x=%h", $time, x1);
      end else if (x1 !== q1[0]) begin
        errors++;
        $display("FAIL sb1_x t=%0t got=%h expected=%h", $time, x1, q1[0]);
      end
      if (q1.size() != 0) void'(q1.pop_front());
    end
    if (v2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL sb2_extra t=%0t x=%h", $time, x2);
      end else if (x2 !== q2[0]) begin
        errors++;
        $display("FAIL sb2_x t=%0t got=%h expected=%h", $time, x2, q2[0]);
      end
      if (q2.size() != 0) void'(q2.pop_front());
    end
  end

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send(input logic [15:0] d, input logic last, input logic [15:0] r);
    int g;
    g = 0;
    in_data   = d;
    in_last   = last;
    recip_len = r;
    in_vld    = 1'b1;
    while (!rdy0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!rdy0) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got_rdy=%b expected=1", rdy0);
    end
    @(negedge clk);
  endtask

  task automatic send_vec(input int n, input logic [15:0] d, input logic [15:0] r);
    for (int i = 0; i < n; i++) send(d, i == n - 1, r);
  endtask

  // lat counts negedges since the edge that accepted in_last.
  task automatic wait_pulse(output int lat);
    lat = 1;
    while (!v0 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1 || v0 !== 1'b0 || x0 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b x=%h expected rdy=1 vld=0 x=0000", rdy0, v0, x0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    send_vec(4, 16'h0100, 16'h4000);
    in_vld = 1'b0;
    wait_pulse(lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL basic_latency got=%0d expected=3", lat);
    end
    checks++;
    if (x0 !== 16'h3F80) begin
      errors++;
      $display("FAIL basic_x got=%h expected=3F80", x0);
    end
    @(negedge clk);
  endtask

  task automatic test_negative();
    int lat;
    send(16'h0200, 1'b0, 16'h8000);
    send(16'hFE00, 1'b1, 16'h8000);
    in_vld = 1'b0;
    wait_pulse(lat);
    checks++;
    if (x0 !== 16'h4080) begin
      errors++;
      $display("FAIL negative_x got=%h expected=4080", x0);
    end
    @(negedge clk);
  endtask

  task automatic test_zero();
    int lat;
    send(16'h0000, 1'b1, 16'h1234);
    in_vld = 1'b0;
    wait_pulse(lat);
    checks++;
    if (x0 !== 16'h3780) begin
      errors++;
      $display("FAIL zero_x got=%h expected=3780", x0);
    end
    @(negedge clk);
  endtask

  task automatic test_rne();
    int lat;
    send_vec(4, 16'h0100, 16'h4000);
    in_vld = 1'b0;
    wait_pulse(lat);
    checks++;
    if (x1 !== 16'h3F80) begin
      errors++;
      $display("FAIL rne_tie_even got=%h expected=3F80", x1);
    end
    checks++;
    if (x2 !== 16'h3F82) begin
      errors++;
      $display("FAIL rne_tie_up got=%h expected=3F82", x2);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int p0, lo, lat;
    p0 = pulses;
    send_vec(4, 16'h0100, 16'h4000);
    in_data = 16'h0100;
    in_last = 1'b0;
    lo = 0;
    while (!rdy0 && lo < 10) begin
      @(negedge clk);
      lo++;
    end
    checks++;
    if (lo != 3) begin
      errors++;
      $display("FAIL b2b_rdy_gap got=%0d expected=3", lo);
    end
    send_vec(4, 16'h0100, 16'h4000);
    in_vld = 1'b0;
    wait_pulse(lat);
    checks++;
    if (x0 !== 16'h3F80) begin
      errors++;
      $display("FAIL b2b_x got=%h expected=3F80", x0);
    end
    @(negedge clk);
    checks++;
    if (pulses - p0 != 2) begin
      errors++;
      $display("FAIL b2b_pulses got=%0d expected=2", pulses - p0);
    end
  endtask

  task automatic test_random();
    int p0, len, g;
    logic [15:0] r, d;
    p0 = pulses;
    for (int v = 0; v < 100; v++) begin
      len = int'($urandom_range(1, 64));
      r   = (len == 1) ? 16'hFFFF : 16'(65536 / len);
      for (int e = 0; e < len; e++) begin
        if ($urandom_range(0, 7) == 0) begin
          in_vld = 1'b0;
          @(negedge clk);
        end
        d = 16'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) d = -d;
        send(d, e == len - 1, r);
      end
      if ($urandom_range(0, 1) == 1) in_vld = 1'b0;
    end
    in_vld = 1'b0;
    g = 0;
    while (q0.size() != 0 && g < 10) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    checks++;
    if (q0.size() != 0 || pulses - p0 != 100) begin
      errors++;
      $display("FAIL random_drain got pending=%0d pulses=%0d expected pending=0 pulses=100", q0.size(), pulses - p0);
    end
  endtask

  task automatic test_reset_mid_vector();
    int p0, lat;
    p0 = pulses;
    send(16'h0100, 1'b0, 16'h4000);
    send(16'h0100, 1'b0, 16'h4000);
    in_vld = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    repeat (6) @(negedge clk);
    checks++;
    if (pulses != p0) begin
      errors++;
      $display("FAIL rst_mid_pulse got=%0d expected=%0d", pulses, p0);
    end
    send_vec(4, 16'h0100, 16'h4000);
    in_vld = 1'b0;
    wait_pulse(lat);
    checks++;
    if (x0 !== 16'h3F80 || lat != 3) begin
      errors++;
      $display("FAIL rst_mid_after got x=%h lat=%0d expected x=3F80 lat=3", x0, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_scale();
    int p0;
    p0 = pulses;
    send_vec(4, 16'h0100, 16'h4000);
    in_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rdy0 !== 1'b1 || v0 !== 1'b0) begin
      errors++;
      $display("FAIL rst_scale_state got rdy=%b vld=%b expected rdy=1 vld=0", rdy0, v0);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    repeat (5) @(negedge clk);
    checks++;
    if (pulses != p0) begin
      errors++;
      $display("FAIL rst_scale_pulse got=%0d expected=%0d", pulses, p0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_zero();
    test_rne();
    test_back_to_back();
    test_random();
    test_reset_mid_vector();
    test_reset_scale();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
